pe_reg: RTL and testbench



---
 rtl/pe_pkg.sv | 25 ++
 rtl/fxp_mac.sv | 47 ++++
 rtl/pe_reg.sv | 40 ++++
 tb/tb_pe_reg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared fixed-point defaults, saturation bounds and saturation helper for the PE array.
package pe_pkg;

   localparam int unsigned PE_WIDTH    = 16;
   localparam int unsigned PE_FRAC_BIT = 10;
   localparam int unsigned PE_SUM_W    = 2 * PE_WIDTH + 1;

   localparam logic signed [PE_WIDTH-1:0] SAT_MAX = {1'b0, {(PE_WIDTH-1){1'b1}}};
   localparam logic signed [PE_WIDTH-1:0] SAT_MIN = {1'b1, {(PE_WIDTH-1){1'b0}}};

   // Clamp a wide signed sum into the PE_WIDTH signed range.
   // The value fits when every bit above the result sign bit equals that sign bit.
   function automatic logic signed [PE_WIDTH-1:0] sat_fxp(input logic signed [PE_SUM_W-1:0] s);
      logic [PE_SUM_W-PE_WIDTH:0] top;
      top = s[PE_SUM_W-1:PE_WIDTH-1];
      if ((&top) || !(|top)) begin
         sat_fxp = s[PE_WIDTH-1:0];
      end else if (s[PE_SUM_W-1]) begin
         sat_fxp = SAT_MIN;
      end else begin
         sat_fxp = SAT_MAX;
      end
   endfunction

endpackage

// File: rtl/fxp_mac.sv
// Combinational fixed-point multiply-accumulate: sat((a*b) >>> FRAC_BIT + c).
module fxp_mac
   import pe_pkg::*;
#(
   parameter int unsigned WIDTH    = PE_WIDTH,
   parameter int unsigned FRAC_BIT = PE_FRAC_BIT
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   input  logic signed [WIDTH-1:0] c,
   output logic signed [WIDTH-1:0] y_c
);

   localparam int unsigned PROD_W = 2 * WIDTH;
   localparam int unsigned SUM_W  = 2 * WIDTH + 1;

   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] prod_sh;
   logic signed [SUM_W-1:0]  sum;

   // Full-precision product, floor rescale, and one-bit-wider accumulate (cannot overflow).
   always_comb begin
      prod    = PROD_W'(a) * PROD_W'(b);
      prod_sh = prod >>> FRAC_BIT;
      sum     = SUM_W'(prod_sh) + SUM_W'(c);
   end

   // Default width reuses the shared helper; other widths use the same sign-run test inline.
   generate
      if (WIDTH == PE_WIDTH) begin : g_pkg_sat
         assign y_c = sat_fxp(sum);
      end else begin : g_gen_sat
         logic [SUM_W-WIDTH:0] top;
         assign top = sum[SUM_W-1:WIDTH-1];
         always_comb begin
            if ((&top) || !(|top)) begin
               y_c = sum[WIDTH-1:0];
            end else if (sum[SUM_W-1]) begin
               y_c = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
               y_c = {1'b0, {(WIDTH-1){1'b1}}};
            end
         end
      end
   endgenerate

endmodule

// File: rtl/pe_reg.sv
// Registered weight-stationary systolic PE: y_out <= sat(a_in*b + y_in), a_out <= a_in.
module pe_reg
   import pe_pkg::*;
#(
   parameter int unsigned WIDTH    = PE_WIDTH,
   parameter int unsigned FRAC_BIT = PE_FRAC_BIT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] a_in,
   input  logic signed [WIDTH-1:0] y_in,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] a_out,
   output logic signed [WIDTH-1:0] y_out
);

   logic signed [WIDTH-1:0] mac_c;

   fxp_mac #(
      .WIDTH    (WIDTH),
      .FRAC_BIT (FRAC_BIT)
   ) u_mac (
      .a   (a_in),
      .b   (b),
      .c   (y_in),
      .y_c (mac_c)
   );

   // Output stage: one register per hop, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_out <= '0;
         y_out <= '0;
      end else begin
         a_out <= a_in;
         y_out <= mac_c;
      end
   end

endmodule

// File: tb/tb_pe_reg.sv
// Self-checking bench for pe_reg: directed spec vectors, random stream vs arithmetic model.
`timescale 1ns/1ps
module tb_pe_reg;

   localparam int unsigned W    = 16;
   localparam int unsigned FRAC = 10;

   logic         clk;
   logic         rst;
   logic [W-1:0] a_in, y_in, b;
   logic [W-1:0] a_out, y_out;

   int n_vec;
   int n_err;

   pe_reg #(.WIDTH(W), .FRAC_BIT(FRAC)) dut (
      .clk   (clk),
      .rst   (rst),
      .a_in  (a_in),
      .y_in  (y_in),
      .b     (b),
      .a_out (a_out),
      .y_out (y_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: real-valued fixed-point MAC with floor rescale and clamping.
   function automatic logic [W-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic [W-1:0] yv);
      longint p, q, s, scale;
      scale = longint'(1) << FRAC;
      p = longint'($signed(av)) * longint'($signed(bv));
      if (p >= 0) q = p / scale;
      else        q = -((-p + scale - 1) / scale);
      s = q + longint'($signed(yv));
      if (s > 32767)       model = 16'h7FFF;
      else if (s < -32768) model = 16'h8000;
      else                 model = W'(s);
   endfunction

   // Drive one vector, clock it, check both outputs 1ns after the edge.
   task automatic apply_check(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic [W-1:0] yv, input logic [W-1:0] exp_y);
      @(negedge clk);
      a_in = av; b = bv; y_in = yv;
      @(posedge clk); #1;
      n_vec++;
      if (y_out !== exp_y) begin
         n_err++;
         $display("FAIL %s y_out: got %h expected %h", name, y_out, exp_y);
      end
      n_vec++;
      if (a_out !== av) begin
         n_err++;
         $display("FAIL %s a_out: got %h expected %h", name, a_out, av);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; a_in = 16'h1234; b = 16'h0400; y_in = 16'h0100;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      n_vec++;
      if (a_out !== 16'h0 || y_out !== 16'h0) begin
         n_err++;
         $display("FAIL reset_async: got a=%h y=%h expected 0000/0000", a_out, y_out);
      end
      @(posedge clk); #1;
      n_vec++;
      if (a_out !== 16'h0 || y_out !== 16'h0) begin
         n_err++;
         $display("FAIL reset_held: got a=%h y=%h expected 0000/0000", a_out, y_out);
      end
      @(negedge clk); rst = 1'b0;
      apply_check("reset_first", 16'h0600, 16'h0800, 16'h0000, 16'h0C00);
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [11];
      logic [W-1:0] tb [11];
      logic [W-1:0] ty [11];
      logic [W-1:0] te [11];
      ta = '{16'hF400, 16'hF000, 16'h1600, 16'hFB33, 16'h0533, 16'h06CC, 16'hFACC, 16'hFACC,
             16'h7FFF, 16'h8000, 16'h0000};
      tb = '{16'h0400, 16'hFC00, 16'h0E00, 16'h0800, 16'h1C00, 16'h1800, 16'h0C00, 16'h1800,
             16'h7FFF, 16'h7FFF, 16'h7FFF};
      ty = '{16'h0400, 16'h0400, 16'h1A00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             16'h7FFF, 16'h8000, 16'h8000};
      te = '{16'hF800, 16'h1400, 16'h6700, 16'hF666, 16'h2465, 16'h28C8, 16'hF064, 16'hE0C8,
             16'h7FFF, 16'h8000, 16'h8000};
      for (int i = 0; i < 11; i++) begin
         apply_check($sformatf("directed_%0d", i), ta[i], tb[i], ty[i], te[i]);
      end
   endtask

   // New vector every cycle; each check looks at the vector applied one edge earlier.
   task automatic test_stream(input string name, input int n, input bit extremes);
      logic [W-1:0] qa[$];
      logic [W-1:0] qy[$];
      logic [W-1:0] av, bv, yv, ea, ey;
      @(negedge clk);
      for (int i = 0; i <= n; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
            ea = qa.pop_front();
            ey = qy.pop_front();
            n_vec++;
            if (y_out !== ey) begin
               n_err++;
               $display("FAIL %s_y[%0d]: got %h expected %h", name, i - 1, y_out, ey);
            end
            n_vec++;
            if (a_out !== ea) begin
               n_err++;
               $display("FAIL %s_a[%0d]: got %h expected %h", name, i - 1, a_out, ea);
            end
         end
         if (i < n) begin
            av = W'($urandom);
            bv = W'($urandom);
            yv = W'($urandom);
            if (extremes) begin
               case ($urandom_range(0, 3))
                  0: av = 16'h8000;
                  1: av = 16'h7FFF;
                  2: bv = 16'h8000;
                  default: yv = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
               endcase
            end
            a_in = av; b = bv; y_in = yv;
            qa.push_back(av);
            qy.push_back(model(av, bv, yv));
         end
      end
   endtask

   // Reset asserted mid-stream must discard the in-flight result.
   task automatic test_midstream_reset();
      @(negedge clk);
      a_in = 16'h0C00; b = 16'h0800; y_in = 16'h0400;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (a_out !== 16'h0 || y_out !== 16'h0) begin
         n_err++;
         $display("FAIL midstream_reset: got a=%h y=%h expected 0000/0000", a_out, y_out);
      end
      @(negedge clk); rst = 1'b0;
      apply_check("post_reset", 16'h0400, 16'hFC00, 16'h0000, 16'hFC00);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      a_in  = '0; b = '0; y_in = '0;
      test_reset();
      test_directed();
      test_stream("stream10", 10, 1'b0);
      test_stream("random", 300, 1'b0);
      test_stream("extreme", 200, 1'b1);
      test_midstream_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
